// File: rtl/mem_ctrl.sv
// Single-port asynchronous SRAM controller: one read or write in flight, a
// programmable number of wait cycles per access, and a one-cycle completion pulse.
module mem_ctrl #(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic                      mem_r_en,
  input  logic                      mem_w_en,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic                      mem_rdy,
  output logic                      mem_cplt,
  output logic [MEM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_dq_out,
  input  logic [DATA_WIDTH-1:0]     sram_dq_in,
  output logic                      sram_dq_oe,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t     state, state_next;
  logic [3:0] wait_cnt;
  logic       is_wr;
  logic       accept;

  // Handshake: a request is taken at a rising edge where mem_rdy=1 and either
  // strobe is high; strobes seen while mem_rdy=0 are ignored, never queued.
  assign accept    = (state == IDLE) && mem_rdy && (mem_r_en || mem_w_en);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_dq_oe = 1'b0;
    mem_cplt   = 1'b0;
    case (state)
      IDLE: begin
        // Write wins when both strobes are high.
        if (accept) state_next = mem_w_en ? WRITE : READ;
      end
      READ: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        if (wait_cnt == 4'd0) state_next = DONE;
      end
      WRITE: begin
        sram_ce_n  = 1'b0;
        sram_we_n  = 1'b0;
        sram_dq_oe = 1'b1;
        if (wait_cnt == 4'd0) state_next = DONE;
      end
      DONE: begin
        // Keep driving write data one extra cycle as data hold time.
        sram_dq_oe = is_wr;
        mem_cplt   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_rdy      <= 1'b0;
      mem_data_out <= '0;
      sram_addr    <= '0;
      sram_dq_out  <= '0;
      wait_cnt     <= 4'd0;
      is_wr        <= 1'b0;
    end else begin
      mem_rdy <= (state_next == IDLE);
      if (accept) begin
        sram_addr   <= mem_addr;
        sram_dq_out <= mem_data_in;
        wait_cnt    <= WAIT_LD;
        is_wr       <= mem_w_en;
      end
      // Counter saturates at zero; the exit edge is the one that sees zero.
      if ((state == READ || state == WRITE) && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (state == READ && wait_cnt == 4'd0)
        mem_data_out <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a 2-wait-cycle instance for read/write/conflict/reset
// scenarios and a zero-wait instance for back-to-back reads.
module tb_mem_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WC = 2;
  localparam logic [1:0] S_IDLE = 2'd0, S_READ = 2'd1, S_WRITE = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // wait-cycle instance
  logic [AW-1:0] mem_addr, sram_addr;
  logic [DW-1:0] mem_data_in, mem_data_out, sram_dq_out, sram_dq_in;
  logic mem_r_en, mem_w_en, mem_rdy, mem_cplt, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0] state_dbg;

  // zero-wait instance
  logic [AW-1:0] addr_z, sram_addr_z;
  logic [DW-1:0] data_out_z, dq_out_z, dq_in_z;
  logic r_en_z, rdy_z, cplt_z, dq_oe_z, ce_n_z, oe_n_z, we_n_z;
  logic [1:0] state_z;

  mem_ctrl #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_data_out(mem_data_out),
    .mem_rdy(mem_rdy), .mem_cplt(mem_cplt), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .state_dbg(state_dbg)
  );

  mem_ctrl #(.MEM_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_CYCLES(0)) u_dut_z (
    .clk(clk), .rst(rst), .mem_addr(addr_z), .mem_data_in(16'h0000),
    .mem_r_en(r_en_z), .mem_w_en(1'b0), .mem_data_out(data_out_z),
    .mem_rdy(rdy_z), .mem_cplt(cplt_z), .sram_addr(sram_addr_z),
    .sram_dq_out(dq_out_z), .sram_dq_in(dq_in_z), .sram_dq_oe(dq_oe_z),
    .sram_ce_n(ce_n_z), .sram_oe_n(oe_n_z), .sram_we_n(we_n_z),
    .state_dbg(state_z)
  );

  // SRAM model for the zero-wait instance: data is a fixed function of address
  assign dq_in_z = sram_addr_z ^ 16'hA5A5;

  int checks = 0;
  int errors = 0;
  int cplt_cnt = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_z_q[$];
  logic [DW-1:0] model_out;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // strobe safety on both instances, every cycle
  always @(negedge clk) begin
    check_eq("oe_we_excl", 32'(!(sram_oe_n == 1'b0 && sram_we_n == 1'b0)), 1);
    check_eq("dqoe_oe_excl", 32'(!(sram_dq_oe == 1'b1 && sram_oe_n == 1'b0)), 1);
    check_eq("z_oe_we_excl", 32'(!(oe_n_z == 1'b0 && we_n_z == 1'b0)), 1);
    check_eq("z_dqoe_oe_excl", 32'(!(dq_oe_z == 1'b1 && oe_n_z == 1'b0)), 1);
  end

  // scoreboard: every completion pops the expected mem_data_out
  always @(negedge clk) begin
    if (mem_cplt) begin
      cplt_cnt++;
      check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_eq("sb_data_out", 32'(mem_data_out), 32'(exp_q.pop_front()));
    end
  end

  // driver: present request (held through back-pressure), then track the access
  task automatic do_req(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic r, input logic w, input logic [DW-1:0] dq,
                        output int waits);
    int lat, oe_cnt, we_cnt, dqoe_cnt;
    mem_addr = addr; mem_data_in = data; mem_r_en = r; mem_w_en = w; sram_dq_in = dq;
    if (w) exp_q.push_back(model_out);
    else begin exp_q.push_back(dq); model_out = dq; end
    waits = 0;
    while (!mem_rdy && waits < 50) begin @(negedge clk); waits++; end
    check_eq("accept_timeout", 32'(waits < 50), 1);
    @(negedge clk);
    mem_r_en = 1'b0; mem_w_en = 1'b0;
    check_eq("busy_state", 32'(state_dbg), w ? 32'(S_WRITE) : 32'(S_READ));
    check_eq("busy_rdy", 32'(mem_rdy), 0);
    lat = 1; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0;
    forever begin
      oe_cnt   += (sram_oe_n == 1'b0) ? 1 : 0;
      we_cnt   += (sram_we_n == 1'b0) ? 1 : 0;
      dqoe_cnt += (sram_dq_oe == 1'b1) ? 1 : 0;
      if (mem_cplt || lat >= 40) break;
      @(negedge clk); lat++;
    end
    check_eq("latency", 32'(lat), 32'(WC + 2));
    check_eq("sram_addr", 32'(sram_addr), 32'(addr));
    check_eq("oe_cycles", 32'(oe_cnt), w ? 0 : 32'(WC + 1));
    check_eq("we_cycles", 32'(we_cnt), w ? 32'(WC + 1) : 0);
    check_eq("dqoe_cycles", 32'(dqoe_cnt), w ? 32'(WC + 2) : 0);
    if (w) check_eq("sram_dq_out", 32'(sram_dq_out), 32'(data));
  endtask

  int zcyc = 0, zlast = -1, zpush = 0, zcplt = 0;

  task automatic z_step(input bit drive);
    @(negedge clk); zcyc++;
    if (cplt_z) begin
      zcplt++;
      if (zlast >= 0) check_eq("z_spacing", 32'(zcyc - zlast), 3);
      zlast = zcyc;
      check_eq("z_nonempty", 32'(exp_z_q.size() > 0), 1);
      if (exp_z_q.size() > 0) check_eq("z_data_out", 32'(data_out_z), 32'(exp_z_q.pop_front()));
    end
    r_en_z = drive;
    addr_z = addr_z + 16'h0011;
    if (drive && rdy_z) begin exp_z_q.push_back(addr_z ^ 16'hA5A5); zpush++; end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waits, c0;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic rr, rw;
    rst = 1'b1; mem_addr = '0; mem_data_in = '0; mem_r_en = 1'b0; mem_w_en = 1'b0;
    sram_dq_in = '0; addr_z = '0; r_en_z = 1'b0; model_out = '0;
    #1 rst = 1'b0;
    #2;
    check_eq("rst_rdy", 32'(mem_rdy), 0);
    check_eq("rst_cplt", 32'(mem_cplt), 0);
    check_eq("rst_data_out", 32'(mem_data_out), 0);
    check_eq("rst_sram_addr", 32'(sram_addr), 0);
    check_eq("rst_dq_out", 32'(sram_dq_out), 0);
    check_eq("rst_dq_oe", 32'(sram_dq_oe), 0);
    check_eq("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    check_eq("rst_state", 32'(state_dbg), 32'(S_IDLE));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #0 check_eq("rel_rdy_low", 32'(mem_rdy), 0);
    @(posedge clk); #1;
    check_eq("rel_rdy_high", 32'(mem_rdy), 1);
    @(negedge clk);

    // read, write, conflict, then a request held through back-pressure
    do_req(16'h0010, 16'h0000, 1'b1, 1'b0, 16'hBEEF, waits);
    check_eq("read_data", 32'(mem_data_out), 32'hBEEF);
    do_req(16'h0020, 16'h1234, 1'b0, 1'b1, 16'hDEAD, waits);
    check_eq("write_keeps_data", 32'(mem_data_out), 32'hBEEF);
    do_req(16'h0040, 16'h5A5A, 1'b1, 1'b1, 16'h1111, waits);
    check_eq("conflict_keeps_data", 32'(mem_data_out), 32'hBEEF);
    do_req(16'h0030, 16'h0000, 1'b1, 1'b0, 16'hCAFE, waits);
    check_eq("backpressure_wait", 32'(waits), 1);

    for (int i = 0; i < 8; i++) begin
      ra = AW'($urandom_range(0, 16'hFFFF));
      rd = DW'($urandom_range(0, 16'hFFFF));
      rr = 1'($urandom_range(0, 1));
      rw = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      do_req(ra, rd, rr, rw, DW'($urandom_range(0, 16'hFFFF)), waits);
    end

    // reset in the second WRITE cycle aborts with no completion
    @(negedge clk);
    mem_addr = 16'h0050; mem_data_in = 16'h7777; mem_w_en = 1'b1;
    @(negedge clk);
    mem_w_en = 1'b0;
    check_eq("abort_in_write", 32'(state_dbg), 32'(S_WRITE));
    @(posedge clk); #2;
    c0 = cplt_cnt;
    rst = 1'b0;
    #1;
    check_eq("abort_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'h7);
    check_eq("abort_dq_oe", 32'(sram_dq_oe), 0);
    check_eq("abort_cplt", 32'(mem_cplt), 0);
    check_eq("abort_rdy", 32'(mem_rdy), 0);
    check_eq("abort_data_out", 32'(mem_data_out), 0);
    model_out = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #0 check_eq("abort_rel_rdy_low", 32'(mem_rdy), 0);
    @(posedge clk); #1;
    check_eq("abort_rel_rdy_high", 32'(mem_rdy), 1);
    check_eq("abort_no_cplt", 32'(cplt_cnt), 32'(c0));
    @(negedge clk);
    do_req(16'h0060, 16'h0000, 1'b1, 1'b0, 16'h0F0F, waits);

    // zero-wait back-to-back reads
    for (int i = 0; i < 14; i++) z_step(1'b1);
    for (int i = 0; i < 5; i++) z_step(1'b0);
    check_eq("z_cplt_count", 32'(zcplt), 32'(zpush));
    check_eq("z_enough", 32'(zcplt >= 4), 1);
    check_eq("sb_drained", 32'(exp_q.size()), 0);
    check_eq("z_drained", 32'(exp_z_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
